sched_q_ctrl: RTL and testbench
===============================

Name: sched_q_ctrl

Overview:
- In-order command scheduler that sequences the DDR5 request shift-queue (chain of valid/rw scheduler cells).
- Accepts requests from the front-end with a valid/ready handshake and drives the queue's one-hot insert select `q_mux`, the rw bit and the shift enable `q_sh_en`.
- Issues the head entry to the command generator. Inserts read-to-write / write-to-read turnaround gaps when the head direction differs from the last issued command.

Parameters:
- Q_MAX, 8, queue depth (number of scheduler cell stages).
- T_RTW, 4, idle cycles required between a read issue and a following write issue.
- T_WTR, 6, idle cycles required between a write issue and a following read issue.
- CNT_W, 4, width of the turnaround counter; must satisfy 2^CNT_W > max(T_RTW, T_WTR).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  front-end request present.
- req_rw  in  1  request direction, 1 = write, 0 = read.
- req_ready  out  1  queue can accept the request this cycle.
- q_mux  out  Q_MAX  one-hot stage select for inserting the new entry; all-zero means no insert.
- q_rw  out  1  rw bit loaded with the insert (equals req_rw).
- q_sh_en  out  1  shift queue toward head (pop head).
- q_valid_in_q  in  1  head stage valid.
- q_rw_in_q  in  1  head stage rw.
- cmd_ready  in  1  downstream timing allows a command this cycle.
- cmd_valid  out  1  command issued this cycle (single-cycle pulse).
- cmd_rw  out  1  direction of the issued command.
- occ  out  $clog2(Q_MAX)+1  current queue occupancy.
- turn_busy  out  1  turnaround wait in progress.

Behaviour:
- Reset (rst=0, async) drives all outputs and state to zero:
  - occ=0, q_mux=0, q_sh_en=0, cmd_valid=0, turn_busy=0, FSM=IDLE.
  - last_rw=0 (read), so a first write after reset waits T_RTW.
- Push: push = req_valid & req_ready.
  - req_ready = (occ < Q_MAX) | pop. Full-and-popping still accepts.
- Pop: pop = issue.
  - issue = q_valid_in_q & cmd_ready & (FSM==ISSUE) & (q_rw_in_q == last_rw).
  - q_sh_en = pop (combinational, same cycle as cmd_valid).
- Insert select:
  - If push & !pop: q_mux bit (Q_MAX-1-occ) = 1.
  - If push & pop: q_mux bit (Q_MAX-occ) = 1, because the entry lands one stage nearer the head after the shift.
  - Otherwise q_mux = 0. q_mux is at most one-hot.
- Occupancy update: occ += push - pop. Simultaneous push and pop leaves occ unchanged. occ never exceeds Q_MAX and never underflows.
- cmd_valid = issue. cmd_rw = q_rw_in_q. Zero latency from head-valid to issue when no turnaround is needed.
- FSM states:
  - IDLE: q_valid_in_q=0. Go to ISSUE when the head becomes valid.
  - ISSUE: head valid.
    - If q_rw_in_q != last_rw: load cnt = (last_rw ? T_WTR : T_RTW) - 1, go to TURN, no issue this cycle.
    - Else issue when cmd_ready. After a pop, stay in ISSUE if the next head is valid, else go to IDLE.
  - TURN: turn_busy=1, cnt decrements every cycle regardless of cmd_ready. When cnt==0: last_rw <= q_rw_in_q, go to ISSUE.
- last_rw updates on each issue to cmd_rw.
- Turnaround gap: the first opposite-direction command issues exactly T_xx cycles after the cycle the mismatch was detected.
- cmd_ready low never aborts TURN. cmd_ready low in ISSUE simply holds.
- Reset asserted mid-TURN or mid-transfer: everything clears immediately. The queue cells are reset by the same rst, so occ=0 stays consistent with the queue.

Decomposition:
- Shared package `sched_pkg`:
  - FSM state typedef {IDLE, ISSUE, TURN}.
  - RW encoding constants RW_READ=0, RW_WRITE=1.
  - Default timing constants T_RTW and T_WTR.
- One natural sub-module: `turn_timer`, a loadable down-counter with a done flag.

Test Plan:
- Reset, then 3 reads pushed back-to-back with cmd_ready=1 → q_mux = 0x80, 0x40, 0x20 across cycles. First cmd_valid appears the cycle the head becomes valid. 3 cmd_valid pulses with cmd_rw=0. occ returns to 0.
- Read issued, then a write at the head → turn_busy high for 4 cycles. Write cmd_valid exactly 4 cycles after mismatch detection. No cmd_valid during TURN.
- Write then read → 6-cycle gap (T_WTR). Repeat with cmd_ready toggling during TURN → gap still exactly 6.
- Fill to occ=8 with cmd_ready=0 → req_ready=0. Then cmd_ready=1 with req_valid=1 → push and pop in the same cycle, q_mux = 0x01, occ stays 8.
- Simultaneous push and pop at occ=3 → q_mux = 0x20, occ stays 3, q_sh_en=1.
- rst low during TURN with occ=5 → all outputs 0 asynchronously. After release, a first write incurs the T_RTW wait.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and default timing for the DDR5 request-queue scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        TURN  = 2'd2
    } sched_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int T_RTW = 4;
    localparam int T_WTR = 6;

endpackage

// File: rtl/sched_q_ctrl_turn_timer.sv
// Loadable down-counter that times the read/write turnaround gap.
module turn_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sched_q_ctrl.sv
// In-order scheduler for the request shift-queue: insert select, head issue, rw turnaround.
//
// state | meaning
// IDLE  | head stage empty
// ISSUE | head valid, issuing in order while direction matches last_rw
// TURN  | waiting out the read/write turnaround gap
module sched_q_ctrl #(
    parameter int Q_MAX = 8,
    parameter int T_RTW = sched_pkg::T_RTW,
    parameter int T_WTR = sched_pkg::T_WTR,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_rw,
    output logic                     req_ready,
    output logic [Q_MAX-1:0]         q_mux,
    output logic                     q_rw,
    output logic                     q_sh_en,
    input  logic                     q_valid_in_q,
    input  logic                     q_rw_in_q,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic                     cmd_rw,
    output logic [$clog2(Q_MAX):0]   occ,
    output logic                     turn_busy
);

    import sched_pkg::*;

    localparam int OCC_W = $clog2(Q_MAX) + 1;

    sched_state_t     state;
    logic             last_rw;
    logic [OCC_W-1:0] occ_r;
    logic             head_ok;
    logic             mismatch;
    logic             issue;
    logic             push;
    logic             pop;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_val;

    // A valid head outside TURN is acted on the same cycle, so IDLE never adds latency.
    assign head_ok  = q_valid_in_q && (state != TURN);
    assign mismatch = head_ok && (q_rw_in_q != last_rw);
    assign issue    = head_ok && !mismatch && cmd_ready;
    assign pop      = issue;

    assign req_ready = (occ_r < OCC_W'(Q_MAX)) || pop;
    assign push      = req_valid && req_ready;

    // The mismatch-detect cycle is the first wait cycle, hence the -2 load.
    assign tmr_val = last_rw ? CNT_W'(T_WTR - 2) : CNT_W'(T_RTW - 2);

    turn_timer #(
        .CNT_W (CNT_W)
    ) u_turn_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (mismatch),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        q_mux = '0;
        for (int i = 0; i < Q_MAX; i++) begin
            if (push && !pop && (int'(occ_r) == Q_MAX - 1 - i)) q_mux[i] = 1'b1;
            if (push && pop && (int'(occ_r) == Q_MAX - i))      q_mux[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_r <= '0;
        end else if (push && !pop) begin
            occ_r <= occ_r + 1'b1;
        end else if (pop && !push && (occ_r != '0)) begin
            occ_r <= occ_r - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last_rw <= RW_READ;
        end else begin
            case (state)
                IDLE, ISSUE: begin
                    if (issue) last_rw <= q_rw_in_q;
                    if (mismatch)          state <= TURN;
                    else if (q_valid_in_q) state <= ISSUE;
                    else                   state <= IDLE;
                end
                TURN: begin
                    if (tmr_done) begin
                        last_rw <= q_rw_in_q;
                        state   <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q_rw      = req_rw;
    assign q_sh_en   = pop;
    assign cmd_valid = issue;
    assign cmd_rw    = q_rw_in_q;
    assign occ       = occ_r;
    assign turn_busy = (state == TURN) || mismatch;

endmodule

// File: tb/tb_sched_q_ctrl.sv
// Directed self-checking bench for sched_q_ctrl.
module tb_sched_q_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic       req_ready;
    logic [7:0] q_mux;
    logic       q_rw;
    logic       q_sh_en;
    logic       q_valid_in_q = 1'b0;
    logic       q_rw_in_q = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic       cmd_rw;
    logic [3:0] occ;
    logic       turn_busy;

    int n_run  = 0;
    int n_fail = 0;

    sched_q_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rw       (req_rw),
        .req_ready    (req_ready),
        .q_mux        (q_mux),
        .q_rw         (q_rw),
        .q_sh_en      (q_sh_en),
        .q_valid_in_q (q_valid_in_q),
        .q_rw_in_q    (q_rw_in_q),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_rw       (cmd_rw),
        .occ          (occ),
        .turn_busy    (turn_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] m;

        // reset state
        #2;
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_q_mux", 32'(q_mux), 32'h0);
        chk("rst_sh_en", 32'(q_sh_en), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_turn_busy", 32'(turn_busy), 32'd0);
        #10;
        rst = 1'b1;

        // three back-to-back reads
        tick();
        req_valid = 1'b1; req_rw = 1'b0; cmd_ready = 1'b1;
        #1;
        chk("rd_mux0", 32'(q_mux), 32'h80);
        chk("rd_qrw0", 32'(q_rw), 32'd0);
        tick();
        chk("rd_occ1", 32'(occ), 32'd1);
        chk("rd_mux1", 32'(q_mux), 32'h40);
        tick();
        chk("rd_mux2", 32'(q_mux), 32'h20);
        tick();
        chk("rd_occ3", 32'(occ), 32'd3);
        req_valid = 1'b0; q_valid_in_q = 1'b1; q_rw_in_q = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rd_cmd_valid", 32'(cmd_valid), 32'd1);
            chk("rd_cmd_rw", 32'(cmd_rw), 32'd0);
            chk("rd_sh_en", 32'(q_sh_en), 32'd1);
            tick();
        end
        chk("rd_occ_end", 32'(occ), 32'd0);
        q_valid_in_q = 1'b0;

        // read followed by write: T_RTW gap
        req_valid = 1'b1; req_rw = 1'b0;
        tick();
        req_rw = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rtw_occ2", 32'(occ), 32'd2);
        q_valid_in_q = 1'b1; q_rw_in_q = 1'b0;
        #1;
        chk("rtw_rd_issue", 32'(cmd_valid), 32'd1);
        tick();
        q_rw_in_q = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rtw_busy", 32'(turn_busy), 32'd1);
            chk("rtw_no_cmd", 32'(cmd_valid), 32'd0);
            tick();
        end
        chk("rtw_wr_issue", 32'(cmd_valid), 32'd1);
        chk("rtw_wr_rw", 32'(cmd_rw), 32'd1);
        chk("rtw_busy_end", 32'(turn_busy), 32'd0);
        tick();
        chk("rtw_occ0", 32'(occ), 32'd0);
        q_valid_in_q = 1'b0;

        // write followed by read: T_WTR gap, cmd_ready toggling during TURN
        req_valid = 1'b1; req_rw = 1'b0;
        tick();
        req_valid = 1'b0;
        q_valid_in_q = 1'b1; q_rw_in_q = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_ready = (i % 2 == 1);
            #1;
            chk("wtr_busy", 32'(turn_busy), 32'd1);
            chk("wtr_no_cmd", 32'(cmd_valid), 32'd0);
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        chk("wtr_rd_issue", 32'(cmd_valid), 32'd1);
        chk("wtr_rd_rw", 32'(cmd_rw), 32'd0);
        tick();
        chk("wtr_occ0", 32'(occ), 32'd0);
        q_valid_in_q = 1'b0;

        // fill to full with cmd_ready low
        cmd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_rw = 1'b0;
            #1;
            m = 8'h80 >> i;
            chk("fill_mux", 32'(q_mux), 32'(m));
            tick();
        end
        #1;
        chk("full_occ", 32'(occ), 32'd8);
        chk("full_not_ready", 32'(req_ready), 32'd0);
        chk("full_no_mux", 32'(q_mux), 32'h0);
        q_valid_in_q = 1'b1; q_rw_in_q = 1'b0; cmd_ready = 1'b1;
        #1;
        chk("full_pp_ready", 32'(req_ready), 32'd1);
        chk("full_pp_mux", 32'(q_mux), 32'h01);
        chk("full_pp_sh_en", 32'(q_sh_en), 32'd1);
        tick();
        chk("full_pp_occ", 32'(occ), 32'd8);

        // drain to 3, then push and pop together
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pp3_occ_before", 32'(occ), 32'd3);
        req_valid = 1'b1;
        #1;
        chk("pp3_mux", 32'(q_mux), 32'h20);
        chk("pp3_sh_en", 32'(q_sh_en), 32'd1);
        tick();
        chk("pp3_occ_after", 32'(occ), 32'd3);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pp3_drained", 32'(occ), 32'd0);
        q_valid_in_q = 1'b0;

        // reset in the middle of a turnaround with occ=5
        req_valid = 1'b1; req_rw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req_valid = 1'b0;
        q_valid_in_q = 1'b1; q_rw_in_q = 1'b1;
        tick();
        tick();
        chk("mid_turn_busy", 32'(turn_busy), 32'd1);
        chk("mid_turn_occ", 32'(occ), 32'd5);
        #2;
        rst = 1'b0; q_valid_in_q = 1'b0; q_rw_in_q = 1'b0;
        #1;
        chk("arst_occ", 32'(occ), 32'd0);
        chk("arst_turn_busy", 32'(turn_busy), 32'd0);
        chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("arst_sh_en", 32'(q_sh_en), 32'd0);
        chk("arst_q_mux", 32'(q_mux), 32'h0);
        #3;
        rst = 1'b1;
        tick();
        req_valid = 1'b1; req_rw = 1'b1;
        #1;
        chk("post_mux", 32'(q_mux), 32'h80);
        tick();
        req_valid = 1'b0;
        q_valid_in_q = 1'b1; q_rw_in_q = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("post_busy", 32'(turn_busy), 32'd1);
            chk("post_no_cmd", 32'(cmd_valid), 32'd0);
            tick();
        end
        chk("post_wr_issue", 32'(cmd_valid), 32'd1);
        chk("post_wr_rw", 32'(cmd_rw), 32'd1);
        tick();
        chk("post_occ0", 32'(occ), 32'd0);
        q_valid_in_q = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
